// File: rtl/axis_dest_scheduler_pkg.sv
// Shared types and defaults for the AXI-Stream destination scheduler:
// source/output FSM encodings, default port counts and the grant-index width helper.
package scheduler_pkg;

  localparam int DEF_S_COUNT = 3;
  localparam int DEF_M_COUNT = 3;

  typedef enum logic [1:0] {
    SRC_FREE   = 2'd0,
    SRC_ROUTED = 2'd1,
    SRC_DROP   = 2'd2
  } src_state_t;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_BUSY = 1'b1
  } out_state_t;

  // Width of one grant index; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_dest_scheduler_if.sv
// Bundle of source-side stream observation signals and grant outputs of the scheduler.
// A source beat is accepted in a cycle where s_tvalid[i] and s_tready[i] are both high.
interface axis_dest_scheduler_if
  import scheduler_pkg::*;
#(
  parameter int S_COUNT         = DEF_S_COUNT,
  parameter int M_COUNT         = DEF_M_COUNT,
  parameter int AXIS_DEST_WIDTH = 9,
  parameter int SEL_WIDTH       = sel_width(S_COUNT)
) ();

  logic [S_COUNT-1:0]                 s_tvalid;
  logic [S_COUNT-1:0]                 s_tready;
  logic [S_COUNT-1:0]                 s_tlast;
  logic [S_COUNT*AXIS_DEST_WIDTH-1:0] s_tdest;
  logic [M_COUNT-1:0]                 m_grant_valid;
  logic [M_COUNT*SEL_WIDTH-1:0]       m_grant_sel;
  logic [S_COUNT-1:0]                 s_granted;
  logic [S_COUNT-1:0]                 s_drop;
  logic                               err_bad_dest;
  logic [2*S_COUNT-1:0]               dbg_src_state;
  logic [M_COUNT-1:0]                 dbg_out_state;

  modport master (
    output s_tvalid, s_tready, s_tlast, s_tdest,
    input  m_grant_valid, m_grant_sel, s_granted, s_drop, err_bad_dest,
    input  dbg_src_state, dbg_out_state
  );

  modport slave (
    input  s_tvalid, s_tready, s_tlast, s_tdest,
    output m_grant_valid, m_grant_sel, s_granted, s_drop, err_bad_dest,
    output dbg_src_state, dbg_out_state
  );

endinterface

// File: rtl/axis_dest_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer, with wrap.
module rr_pick
  import scheduler_pkg::*;
#(
  parameter int N = DEF_S_COUNT,
  parameter int W = sel_width(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic         o_found,
  output logic [W-1:0] o_index
);

  // Scan from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    o_found = 1'b0;
    o_index = '0;
    for (int off = N - 1; off >= 0; off--) begin
      if (i_req[(int'(i_ptr) + off) % N]) begin
        o_found = 1'b1;
        o_index = W'((int'(i_ptr) + off) % N);
      end
    end
  end

endmodule

// File: rtl/axis_dest_scheduler.sv
// Packet-level grant scheduler for an S_COUNT x M_COUNT AXI-Stream crossbar, with per-output
// round-robin arbitration and a discard grant for sources whose tdest is out of range.
module axis_dest_scheduler
  import scheduler_pkg::*;
#(
  parameter int S_COUNT         = DEF_S_COUNT,
  parameter int M_COUNT         = DEF_M_COUNT,
  parameter int AXIS_DEST_WIDTH = 9,
  parameter int SEL_WIDTH       = sel_width(S_COUNT)
) (
  input logic                  clk,
  input logic                  rst,
  axis_dest_scheduler_if.slave bus
);

  src_state_t                 r_src_state [S_COUNT];
  src_state_t                 w_src_next  [S_COUNT];
  logic [SEL_WIDTH-1:0]       r_dest_lock [S_COUNT];
  logic [SEL_WIDTH-1:0]       w_lock_next [S_COUNT];
  logic [AXIS_DEST_WIDTH-1:0] w_dest      [S_COUNT];

  out_state_t           r_out_state [M_COUNT];
  out_state_t           w_out_next  [M_COUNT];
  logic [SEL_WIDTH-1:0] r_rr_ptr    [M_COUNT];
  logic [SEL_WIDTH-1:0] w_ptr_next  [M_COUNT];
  logic [SEL_WIDTH-1:0] r_sel       [M_COUNT];
  logic [SEL_WIDTH-1:0] w_sel_next  [M_COUNT];
  logic [SEL_WIDTH-1:0] w_pick      [M_COUNT];
  logic [S_COUNT-1:0]   w_req       [M_COUNT];

  logic [M_COUNT-1:0] w_found;
  logic [M_COUNT-1:0] w_release;
  logic [S_COUNT-1:0] w_last_acc;
  logic [S_COUNT-1:0] w_bad;
  logic [S_COUNT-1:0] w_src_grant;

  logic [M_COUNT-1:0] r_grant_valid;
  logic [S_COUNT-1:0] r_granted;
  logic [S_COUNT-1:0] r_drop;
  logic               r_err;

  for (genvar i = 0; i < S_COUNT; i++) begin : g_src
    assign w_dest[i] = bus.s_tdest[i*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH];
    assign bus.dbg_src_state[2*i +: 2] = r_src_state[i];
  end

  // Requests come only from FREE sources; release is keyed off the locked destination.
  always_comb begin
    w_last_acc = '0;
    w_bad      = '0;
    w_release  = '0;
    for (int i = 0; i < S_COUNT; i++) begin
      w_last_acc[i] = bus.s_tvalid[i] & bus.s_tready[i] & bus.s_tlast[i];
      w_bad[i]      = (r_src_state[i] == SRC_FREE) & bus.s_tvalid[i] &
                      (w_dest[i] >= AXIS_DEST_WIDTH'(M_COUNT));
    end
    for (int j = 0; j < M_COUNT; j++) begin
      w_req[j] = '0;
      for (int i = 0; i < S_COUNT; i++) begin
        w_req[j][i] = (r_src_state[i] == SRC_FREE) & bus.s_tvalid[i] &
                      (w_dest[i] == AXIS_DEST_WIDTH'(j));
        if ((r_src_state[i] == SRC_ROUTED) && w_last_acc[i] &&
            (r_dest_lock[i] == SEL_WIDTH'(j)))
          w_release[j] = 1'b1;
      end
    end
  end

  for (genvar j = 0; j < M_COUNT; j++) begin : g_out
    rr_pick #(
      .N (S_COUNT),
      .W (SEL_WIDTH)
    ) u_pick (
      .i_req   (w_req[j]),
      .i_ptr   (r_rr_ptr[j]),
      .o_found (w_found[j]),
      .o_index (w_pick[j])
    );
    assign bus.m_grant_sel[j*SEL_WIDTH +: SEL_WIDTH] = r_sel[j];
    assign bus.dbg_out_state[j] = r_out_state[j];
  end

  // Output FSMs: arbitrate when idle or on the owner's release cycle (direct hand-over).
  always_comb begin
    w_src_grant = '0;
    for (int j = 0; j < M_COUNT; j++) begin
      w_out_next[j] = r_out_state[j];
      w_ptr_next[j] = r_rr_ptr[j];
      w_sel_next[j] = r_sel[j];
      if ((r_out_state[j] == OUT_IDLE) || w_release[j]) begin
        if (w_found[j]) begin
          w_out_next[j] = OUT_BUSY;
          w_sel_next[j] = w_pick[j];
          w_ptr_next[j] = (w_pick[j] == SEL_WIDTH'(S_COUNT - 1)) ? '0 : w_pick[j] + 1'b1;
          w_src_grant[w_pick[j]] = 1'b1;
        end else begin
          w_out_next[j] = OUT_IDLE;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < S_COUNT; i++) begin
      w_src_next[i]  = r_src_state[i];
      w_lock_next[i] = r_dest_lock[i];
      case (r_src_state[i])
        SRC_FREE: begin
          if (w_src_grant[i]) begin
            w_src_next[i]  = SRC_ROUTED;
            w_lock_next[i] = w_dest[i][SEL_WIDTH-1:0];
          end else if (w_bad[i]) begin
            w_src_next[i] = SRC_DROP;
          end
        end
        SRC_ROUTED, SRC_DROP: begin
          if (w_last_acc[i]) w_src_next[i] = SRC_FREE;
        end
        default: w_src_next[i] = SRC_FREE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < S_COUNT; i++) begin
        r_src_state[i] <= SRC_FREE;
        r_dest_lock[i] <= '0;
      end
      for (int j = 0; j < M_COUNT; j++) begin
        r_out_state[j] <= OUT_IDLE;
        r_rr_ptr[j]    <= '0;
        r_sel[j]       <= '0;
      end
      r_grant_valid <= '0;
      r_granted     <= '0;
      r_drop        <= '0;
      r_err         <= 1'b0;
    end else begin
      for (int i = 0; i < S_COUNT; i++) begin
        r_src_state[i] <= w_src_next[i];
        r_dest_lock[i] <= w_lock_next[i];
        r_granted[i]   <= (w_src_next[i] == SRC_ROUTED);
        r_drop[i]      <= (w_src_next[i] == SRC_DROP);
      end
      for (int j = 0; j < M_COUNT; j++) begin
        r_out_state[j]   <= w_out_next[j];
        r_rr_ptr[j]      <= w_ptr_next[j];
        r_sel[j]         <= w_sel_next[j];
        r_grant_valid[j] <= (w_out_next[j] == OUT_BUSY);
      end
      r_err <= |w_bad;
    end
  end

  assign bus.m_grant_valid = r_grant_valid;
  assign bus.s_granted     = r_granted;
  assign bus.s_drop        = r_drop;
  assign bus.err_bad_dest  = r_err;

endmodule

// File: tb/tb_axis_dest_scheduler.sv
// Randomized bench for axis_dest_scheduler: per-source packet generators, an ownership-level
// reference model, per-cycle output checks and an ordered grant-event scoreboard.
module tb_axis_dest_scheduler;
  import scheduler_pkg::*;

  localparam int S  = 3;
  localparam int M  = 3;
  localparam int DW = 9;
  localparam int SW = sel_width(S);

  logic clk;
  logic rst;

  axis_dest_scheduler_if #(.S_COUNT(S), .M_COUNT(M), .AXIS_DEST_WIDTH(DW), .SEL_WIDTH(SW)) bus ();

  axis_dest_scheduler #(
    .S_COUNT (S), .M_COUNT (M), .AXIS_DEST_WIDTH (DW), .SEL_WIDTH (SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_bad   = 0;

  // packet generators
  int g_en[S], g_fix_dest[S], g_fix_len[S];
  int g_act[S], g_left[S], g_dest[S], g_gap[S];
  int gap_max, ready_pct;

  // reference model: owner per output (-1 none), holding per source (-1 free, M = discard)
  int m_owner[M], m_ptr[M], m_lastsel[M], m_hold[S];
  bit m_err;
  int n_owner[M], n_ptr[M], n_lastsel[M], n_hold[S];
  bit n_err;
  bit acc[S];
  bit rst_edge;

  // scoreboard of grant events, encoded as output*16 + source
  logic [7:0] exp_q[$];
  logic [M-1:0] p_gv;
  logic [SW-1:0] p_sel[M];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_src(input int i, input int en, input int dest, input int len);
    g_en[i] = en; g_fix_dest[i] = dest; g_fix_len[i] = len;
  endtask

  task automatic drive_inputs();
    logic [S-1:0] v, r, l;
    logic [S*DW-1:0] d;
    v = '0; r = '0; l = '0; d = '0;
    for (int i = 0; i < S; i++) begin
      if (g_act[i] == 0 && g_en[i] != 0) begin
        if (g_gap[i] > 0) g_gap[i]--;
        else begin
          g_act[i]  = 1;
          g_left[i] = (g_fix_len[i] > 0) ? g_fix_len[i] : int'($urandom_range(1, 4));
          if (g_fix_dest[i] >= 0) g_dest[i] = g_fix_dest[i];
          else if ($urandom_range(0, 9) == 0) g_dest[i] = int'($urandom_range(M, 511));
          else g_dest[i] = int'($urandom_range(0, M - 1));
        end
      end
      v[i] = (g_act[i] != 0);
      l[i] = v[i] && (g_left[i] == 1);
      d[i*DW +: DW] = DW'(g_dest[i]);
      r[i] = (m_hold[i] >= 0) && ($urandom_range(0, 99) < ready_pct);
    end
    bus.s_tvalid = v;
    bus.s_tready = r;
    bus.s_tlast  = l;
    bus.s_tdest  = d;
  endtask

  task automatic model_next();
    bit found;
    int k;
    rst_edge = !rst;
    for (int i = 0; i < S; i++) acc[i] = bus.s_tvalid[i] & bus.s_tready[i];
    n_err = 1'b0;
    if (rst_edge) begin
      for (int j = 0; j < M; j++) begin n_owner[j] = -1; n_ptr[j] = 0; n_lastsel[j] = 0; end
      for (int i = 0; i < S; i++) n_hold[i] = -1;
    end else begin
      for (int i = 0; i < S; i++)
        n_hold[i] = (m_hold[i] >= 0 && acc[i] && bus.s_tlast[i]) ? -1 : m_hold[i];
      for (int j = 0; j < M; j++) begin
        n_owner[j] = m_owner[j]; n_ptr[j] = m_ptr[j]; n_lastsel[j] = m_lastsel[j];
        if (m_owner[j] < 0 || (acc[m_owner[j]] && bus.s_tlast[m_owner[j]])) begin
          n_owner[j] = -1;
          found = 1'b0;
          for (int s = 0; s < S; s++) begin
            k = (m_ptr[j] + s) % S;
            if (!found && m_hold[k] == -1 && bus.s_tvalid[k] && g_dest[k] == j) begin
              found = 1'b1; n_owner[j] = k; n_ptr[j] = (k + 1) % S; n_lastsel[j] = k; n_hold[k] = j;
            end
          end
        end
      end
      for (int i = 0; i < S; i++)
        if (m_hold[i] == -1 && bus.s_tvalid[i] && g_dest[i] >= M) begin
          n_hold[i] = M; n_err = 1'b1;
        end
    end
  endtask

  task automatic commit_and_check();
    logic [M-1:0] e_gv;
    logic [M*SW-1:0] e_sel;
    logic [S-1:0] e_gr, e_dr;
    logic [SW-1:0] sel_j;
    logic [7:0] exp_ev;
    for (int j = 0; j < M; j++)
      if (n_owner[j] >= 0 && n_owner[j] != m_owner[j]) exp_q.push_back(8'(j*16 + n_owner[j]));
    m_owner = n_owner; m_ptr = n_ptr; m_lastsel = n_lastsel; m_hold = n_hold; m_err = n_err;
    e_gv = '0; e_sel = '0; e_gr = '0; e_dr = '0;
    for (int j = 0; j < M; j++) begin
      e_gv[j] = (m_owner[j] >= 0);
      e_sel[j*SW +: SW] = SW'(m_lastsel[j]);
    end
    for (int i = 0; i < S; i++) begin
      e_gr[i] = (m_hold[i] >= 0 && m_hold[i] < M);
      e_dr[i] = (m_hold[i] == M);
    end
    check_val("grant_valid", 32'(bus.m_grant_valid), 32'(e_gv));
    check_val("grant_sel", 32'(bus.m_grant_sel), 32'(e_sel));
    check_val("s_granted", 32'(bus.s_granted), 32'(e_gr));
    check_val("s_drop", 32'(bus.s_drop), 32'(e_dr));
    check_val("err_bad_dest", 32'(bus.err_bad_dest), 32'(m_err));
    for (int j = 0; j < M; j++) begin
      sel_j = bus.m_grant_sel[j*SW +: SW];
      if (bus.m_grant_valid[j] && (!p_gv[j] || sel_j != p_sel[j])) begin
        exp_ev = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hff;
        check_val("grant_order", 32'(j*16 + int'(sel_j)), 32'(exp_ev));
      end
      p_sel[j] = sel_j;
    end
    p_gv = bus.m_grant_valid;
  endtask

  task automatic consume();
    for (int i = 0; i < S; i++) begin
      if (rst_edge) begin
        g_act[i] = 0; g_gap[i] = 0;
      end else if (acc[i]) begin
        g_left[i]--;
        if (g_left[i] == 0) begin
          g_act[i] = 0; g_gap[i] = int'($urandom_range(0, gap_max));
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      drive_inputs();
      model_next();
      @(posedge clk);
      #1;
      commit_and_check();
      consume();
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b0;
    run(2);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    gap_max = 0; ready_pct = 100;
    p_gv = '0;
    for (int j = 0; j < M; j++) begin
      m_owner[j] = -1; m_ptr[j] = 0; m_lastsel[j] = 0; p_sel[j] = '0;
    end
    for (int i = 0; i < S; i++) begin
      m_hold[i] = -1; g_act[i] = 0; g_left[i] = 0; g_dest[i] = 0; g_gap[i] = 0;
      set_src(i, 1, -1, 0);
    end

    // reset held with every source valid
    run(4);
    check_val("rst_hold_gv", 32'(bus.m_grant_valid), 32'd0);
    check_val("rst_hold_granted", 32'(bus.s_granted), 32'd0);
    rst = 1'b1;
    set_src(0, 1, 1, 2); set_src(1, 0, 0, 0); set_src(2, 0, 0, 0);
    run(1);
    check_val("first_gv1", 32'(bus.m_grant_valid[1]), 32'd1);
    check_val("first_sel1", 32'(bus.m_grant_sel[1*SW +: SW]), 32'd0);
    run(6);

    // three-way contention on output 2
    reset_pulse();
    for (int i = 0; i < S; i++) set_src(i, 1, 2, 3);
    run(40);

    // fairness: single-beat stream from source 0 against source 2
    reset_pulse();
    set_src(0, 1, 0, 1); set_src(1, 0, 0, 0); set_src(2, 1, 0, 2);
    run(30);

    // back-pressure with random traffic
    reset_pulse();
    for (int i = 0; i < S; i++) set_src(i, 1, -1, 0);
    ready_pct = 25; gap_max = 2;
    run(200);

    // bad destination alongside a legal grant
    reset_pulse();
    ready_pct = 100; gap_max = 1;
    set_src(0, 1, 1, 3); set_src(1, 1, 7, 2); set_src(2, 0, 0, 0);
    run(30);

    // reset in the middle of a 4-beat packet
    reset_pulse();
    gap_max = 0;
    set_src(0, 1, 0, 4); set_src(1, 0, 0, 0);
    run(3);
    rst = 1'b0;
    run(1);
    check_val("rst_mid_gv", 32'(bus.m_grant_valid), 32'd0);
    rst = 1'b1;
    run(10);

    // long random run with occasional resets
    for (int i = 0; i < S; i++) set_src(i, 1, -1, 0);
    ready_pct = 70; gap_max = 3;
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 199) != 0);
      run(1);
    end
    rst = 1'b1;
    run(5);

    check_val("grant_q_left", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/axis_dest_scheduler.md
# axis_dest_scheduler

Packet-level scheduler for the 3×3 AXI-Stream crossbar in the data-processing scheduler path. It watches each source's `tvalid`/`tdest`/`tlast` and the accepted-beat handshake. For every output it issues a registered grant naming one source, held from the packet's first beat to its `tlast` beat. Arbitration is round-robin per output. It also detects out-of-range `tdest` and grants that source to a discard path, so the crossbar datapath becomes a pure mux driven by these grants.

## Interface
Parameters:
- `S_COUNT`, 3, number of source ports.
- `M_COUNT`, 3, number of output ports.
- `AXIS_DEST_WIDTH`, 9, width of each source `tdest`.
- `SEL_WIDTH`, `$clog2(S_COUNT)` (minimum 1), width of one grant index.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset).
- `s_tvalid`  in  S_COUNT  source valid, bit i = source i.
- `s_tready`  in  S_COUNT  datapath ready toward source i; a beat is accepted when `s_tvalid[i] & s_tready[i]`.
- `s_tlast`  in  S_COUNT  source last-beat flag.
- `s_tdest`  in  S_COUNT*AXIS_DEST_WIDTH  source destination; slice i = `[i*AXIS_DEST_WIDTH +: AXIS_DEST_WIDTH]`.
- `m_grant_valid`  out  M_COUNT  output j currently owned by a source.
- `m_grant_sel`  out  M_COUNT*SEL_WIDTH  index of the source owning output j.
- `s_granted`  out  S_COUNT  source i holds a grant to a valid output.
- `s_drop`  out  S_COUNT  source i holds the discard grant (bad `tdest`).
- `err_bad_dest`  out  1  one-cycle pulse when a discard grant is issued.

## Operation
- Each output j has a 2-state FSM: IDLE, BUSY.
- Each source i has a 3-state FSM: FREE, ROUTED, DROP. It also has a registered `dest_lock` (`SEL_WIDTH`…`AXIS_DEST_WIDTH` bits).
- Request: source i requests output j when it is FREE, `s_tvalid[i]` is high and `s_tdest` slice i == j.
  - `tdest` is sampled only while the source is FREE.
  - The source must hold `tdest` stable through the packet; the scheduler uses `dest_lock` after grant.
- Arbitration for output j in IDLE, or in BUSY on its release cycle:
  - Pick the first requester scanning from `rr_ptr[j]` upward, with wrap-around.
  - On grant to source k: `rr_ptr[j] <= (k+1) mod S_COUNT`, output → BUSY, source k → ROUTED.
- Release: when an accepted beat with `s_tlast` occurs for the owner of output j:
  - The owner → FREE.
  - If another source requests j in the same cycle, the grant switches directly to it. There is no idle cycle, and output j stays BUSY.
  - Otherwise output j → IDLE.
  - The releasing source may re-request only from the next cycle.
- Bad dest: a FREE source with `s_tvalid` and `tdest >= M_COUNT`:
  - The source → DROP and `err_bad_dest` pulses on the same edge.
  - The source stays in DROP until its accepted `tlast` beat, then returns to FREE.
  - DROP never touches any output FSM.
- Single-beat packets: the grant is issued, then the first accepted beat carries `tlast` and releases on that edge.
- Without handshake, the grant is held indefinitely; there is no timeout.
- Multiple outputs: they arbitrate independently in the same cycle. A source requests at most one output, so no source is double-granted.

## Timing
- Reset (`rst`=0 at an edge):
  - Outputs: `m_grant_valid`, `s_granted`, `s_drop`, `err_bad_dest` = 0; `m_grant_sel` = 0.
  - State: all FSMs → IDLE/FREE; `rr_ptr` = 0.
  - Reset mid-packet drops every grant on that edge.
- All outputs are registered.
- Grant latency: request present at edge N → `m_grant_valid[j]`/`m_grant_sel` valid after edge N. The datapath may accept the first beat in cycle N+1.
- Release latency: accepted `tlast` beat in cycle K → grant cleared or switched after edge K.
- `m_grant_sel[j]` holds its last value while `m_grant_valid[j]` = 0.
- Throughput: back-to-back packets from different sources to one output need no bubble. The same source sending two packets to one output incurs a 1-cycle bubble.

## Structure
- Shared package `scheduler_pkg` holds:
  - Source FSM encodings: FREE=0, ROUTED=1, DROP=2.
  - Output FSM encodings: IDLE=0, BUSY=1.
  - Default `S_COUNT`/`M_COUNT`.
  - The `SEL_WIDTH` clog2 helper.
- One sub-module, `rr_pick`: combinational round-robin picker.
  - Inputs: request vector, pointer.
  - Outputs: `found` and `index`.
  - Instantiate it `M_COUNT` times.
- Estimated 200–300 lines of RTL.

## Test plan
- Reset hold: `rst`=0 for 4 cycles with all sources valid → all outputs 0. After release, source 0 with `tdest`=1 → `m_grant_valid[1]`=1 and sel=0 one cycle later.
- Contention: sources 0, 1, 2 all `tdest`=2 sending 3-beat packets, always ready → output 2 grant order 0, 1, 2. No idle cycle between packets; each grant lasts exactly 3 beats.
- Fairness: source 0 streams 1-beat packets to output 0 while source 2 requests output 0 → grant alternates 0, 2, 0, 2; source 0 shows its 1-cycle re-request bubble.
- Back-pressure: `s_tready` low for 5 cycles mid-packet → grant held unchanged; release on the first accepted `tlast` beat only.
- Bad dest: source 1 `tdest`=7 with a 2-beat packet → `err_bad_dest` pulses once and `s_drop[1]`=1 for 2 accepted beats. `m_grant_valid` is unaffected, and source 0 → output 1 is granted concurrently.
- Reset mid-packet: assert `rst` during beat 2 of a 4-beat packet → all grants 0 next cycle. After release, a fresh request is granted from `rr_ptr`=0.
